fpu: RTL and testbench
======================

// Module: fpu
// PURPOSE
//  Pipelined 9-bit floating-point adder/subtractor for the simple processor datapath.
//  Computes S = A + B (ADDSUB=0) or S = A - B (ADDSUB=1) and flags a zero result.
//  Number format is 1 sign bit, 4 exponent bits (bias 7) and 4 fraction bits; there is no Inf or NaN.
//  Results are registered, with a fixed 2-cycle latency.
// PARAMETERS
//  none (format fixed: EXP_W=4, FRAC_W=4, BIAS=7)
// PORTS
//  clk        in   1  sole clock, rising edge
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  A/B/ADDSUB sampled this cycle
//  A          in   9  operand {sign[8], exp[7:4], frac[3:0]}
//  B          in   9  operand, same format
//  ADDSUB     in   1  0 = add, 1 = subtract (A - B)
//  S          out  9  result, same format
//  ZERO       out  1  S is zero (S == 9'h000)
//  OVF        out  1  magnitude overflow; S saturated
//  out_valid  out  1  S/ZERO/OVF valid this cycle
// BEHAVIOUR
//  - One clock, with a synchronous active-high reset. On rst: S=0, ZERO=1, OVF=0, out_valid=0, and all pipeline valids cleared.
//  - Value encoding:
//    - exp!=0: (-1)^s * 1.frac * 2^(exp-7).
//    - exp==0: zero for any frac (denormals are flushed on input).
//    - exp==15: an ordinary normal value.
//  - Latency and throughput:
//    - Inputs sampled at edge N (when in_valid=1); result and out_valid=1 at edge N+2.
//    - One operation per cycle, no stall or backpressure.
//    - out_valid=0 on cycles with no op in flight; S/ZERO/OVF hold their last value.
//  - Stage 1:
//    - Effective B sign = B.sign XOR ADDSUB.
//    - Swap operands so the larger magnitude (compare {exp,frac}) is first.
//    - Right-shift the smaller significand (hidden 1 + frac) by the exponent difference.
//    - Keep guard, round and sticky bits. A shift >=7 leaves only sticky.
//  - Stage 2:
//    - Add or subtract significands (sign-magnitude). Result sign = larger operand's sign.
//    - Normalize: on carry out, shift right 1 and exp+1; otherwise shift left by the leading-zero count and decrement exp.
//    - Round to nearest, ties to even, using guard/round/sticky. A rounding carry renormalizes and exp+1.
//  - Exact cancellation (equal magnitudes with effective subtract) or zero significand: S=9'b0_0000_0000 (+0), ZERO=1.
//  - Zero operands: X+0 returns X exactly; 0-X returns X with its sign flipped; 0+-0 returns +0.
//  - Underflow: a normalized exp below 1 flushes S to +0 with ZERO=1 (no underflow flag).
//  - Overflow: an exp above 15 after normalize or round gives S={sign,4'b1111,4'b1111} and OVF=1.
//  - ZERO and OVF are mutually exclusive; both are registered with S.
//  - rst asserted mid-operation discards in-flight ops; out_valid stays 0 until 2 cycles after the next in_valid.
// TESTING
//  1. 0.25 + 0.125: A=9'b0_0101_0000, B=9'b0_0100_0000, ADDSUB=0 -> S=9'b0_0101_1000 (0.375), ZERO=0.
//  2. Exact cancellation: A=B=9'b0_0001_0000, ADDSUB=1 -> S=9'b0_0000_0000, ZERO=1.
//  3. 1.0 - 1.5: A=9'b0_0111_0000, B=9'b0_0111_1000, ADDSUB=1 -> S=9'b1_0110_0000 (-0.5), ZERO=0.
//  4. Tie-to-even: A=9'b0_1011_1100 (28), B=9'b0_0111_1000 (1.5), ADDSUB=1 -> S=9'b0_1011_1010 (26), ZERO=0.
//  5. Overflow: A=B=9'b0_1111_1111, ADDSUB=0 -> S=9'b0_1111_1111, OVF=1.
//  6. Throughput and reset:
//     - in_valid on back-to-back cycles with tests 1-4 gives results on 4 consecutive cycles starting 2 cycles later.
//     - rst pulsed mid-stream gives out_valid=0, S=0, ZERO=1 on the following cycle.

Source files
------------

// File: rtl/fpu_if.sv
// Operand/result bundle for the 9-bit floating-point adder.
// Master drives the operands; slave returns the registered result.
interface fpu_if;
  logic       in_valid;
  logic [8:0] A;
  logic [8:0] B;
  logic       ADDSUB;
  logic [8:0] S;
  logic       ZERO;
  logic       OVF;
  logic       out_valid;

  modport master (
    output in_valid, A, B, ADDSUB,
    input  S, ZERO, OVF, out_valid
  );

  modport slave (
    input  in_valid, A, B, ADDSUB,
    output S, ZERO, OVF, out_valid
  );
endinterface

// File: rtl/fpu.sv
// Pipelined 9-bit float add/sub: {sign, exp[3:0] bias 7, frac[3:0]}.
// Align, then add+normalize, then round; results two edges after sampling.
module fpu (
  input  logic clk,
  input  logic rst,
  fpu_if.slave bus
);

  logic       swap;
  logic       sa, sb, sl, ss;
  logic [7:0] ml, ms;
  logic [4:0] sigl, sigs;
  logic [3:0] d;
  logic [21:0] w;

  always_comb begin
    sa   = bus.A[8];
    sb   = bus.B[8] ^ bus.ADDSUB;
    swap = bus.B[7:0] > bus.A[7:0];
    sl   = swap ? sb : sa;
    ss   = swap ? sa : sb;
    ml   = swap ? bus.B[7:0] : bus.A[7:0];
    ms   = swap ? bus.A[7:0] : bus.B[7:0];
    sigl = (ml[7:4] != 4'd0) ? {1'b1, ml[3:0]} : 5'd0;
    sigs = (ms[7:4] != 4'd0) ? {1'b1, ms[3:0]} : 5'd0;
    d    = ml[7:4] - ms[7:4];
    w    = {sigs, 2'b00, 15'd0} >> d;
  end

  logic       s1_valid, s1_sign, s1_sub;
  logic [3:0] s1_exp;
  logic [4:0] s1_l;
  logic [7:0] s1_s;

  logic [8:0]        sum;
  logic [3:0]        lz;
  logic [7:0]        nm;
  logic signed [5:0] ne;

  always_comb begin
    if (s1_sub)
      sum = {1'b0, s1_l, 3'b000} - {1'b0, s1_s};
    else
      sum = {1'b0, s1_l, 3'b000} + {1'b0, s1_s};
    lz = 4'd8;
    for (int i = 0; i < 8; i++)
      if (sum[i]) lz = 4'(7 - i);
    if (sum[8]) begin
      nm = {sum[8:2], |sum[1:0]};
      ne = {2'b00, s1_exp} + 6'd1;
    end else begin
      nm = sum[7:0] << lz;
      ne = {2'b00, s1_exp} - {2'b00, lz};
    end
  end

  logic              s2_valid, s2_sign, s2_zero;
  logic [7:0]        s2_m;
  logic signed [5:0] s2_e;

  // nm = {sig[4:0], guard, round, sticky}
  logic              rnd;
  logic [5:0]        sig6;
  logic signed [5:0] ef;
  logic [8:0]        r_s;
  logic              r_zero, r_ovf;

  always_comb begin
    rnd  = s2_m[2] & (s2_m[1] | s2_m[0] | s2_m[3]);
    sig6 = {1'b0, s2_m[7:3]} + {5'd0, rnd};
    ef   = s2_e + {5'd0, sig6[5]};
    r_s    = 9'd0;
    r_zero = 1'b0;
    r_ovf  = 1'b0;
    if (s2_zero || s2_e < 6'sd1) begin
      r_zero = 1'b1;
    end else if (ef > 6'sd15) begin
      r_s   = {s2_sign, 8'hFF};
      r_ovf = 1'b1;
    end else begin
      r_s = {s2_sign, ef[3:0], sig6[5] ? 4'd0 : sig6[3:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_sign       <= 1'b0;
      s1_sub        <= 1'b0;
      s1_exp        <= 4'd0;
      s1_l          <= 5'd0;
      s1_s          <= 8'd0;
      s2_valid      <= 1'b0;
      s2_sign       <= 1'b0;
      s2_zero       <= 1'b1;
      s2_m          <= 8'd0;
      s2_e          <= 6'sd0;
      bus.S         <= 9'd0;
      bus.ZERO      <= 1'b1;
      bus.OVF       <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign <= sl;
        s1_sub  <= sl ^ ss;
        s1_exp  <= ml[7:4];
        s1_l    <= sigl;
        s1_s    <= {w[21:15], |w[14:0]};
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_zero <= (sum == 9'd0);
        s2_m    <= nm;
        s2_e    <= ne;
      end
      bus.out_valid <= s2_valid;
      if (s2_valid) begin
        bus.S    <= r_s;
        bus.ZERO <= r_zero;
        bus.OVF  <= r_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fpu.sv
// Randomized bench for fpu against an exact-integer reference model.
// Checks output every cycle, including reset and hold behaviour.
module tb_fpu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  fpu_if bus ();

  fpu dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    logic [10:0] r;
  } exp_t;
  exp_t q[$];

  // value = mag * 2^-10, computed exactly, then rounded to nearest-even
  function automatic int mag(logic [8:0] x);
    logic [3:0] e;
    logic [3:0] f;
    e = x[7:4];
    f = x[3:0];
    if (e == 4'd0) return 0;
    return (16 + int'(f)) << (int'(e) - 1);
  endfunction

  function automatic logic [10:0] ref_op(logic [8:0] a, logic [8:0] b,
                                         logic op);
    int va, vb, m, p, sh, qq, rem, half, e;
    logic neg, sbn;
    sbn = b[8] ^ op;
    va = a[8] ? -mag(a) : mag(a);
    vb = sbn ? -mag(b) : mag(b);
    m = va + vb;
    if (m == 0) return {2'b01, 9'd0};
    neg = (m < 0);
    if (neg) m = -m;
    p = 0;
    for (int i = 0; i < 24; i++)
      if (((m >> i) & 1) == 1) p = i;
    sh = p - 4;
    if (sh > 0) begin
      qq = m >> sh;
      rem = m - (qq << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (qq % 2) == 1)) qq++;
      if (qq == 32) begin
        qq = 16;
        sh++;
      end
    end else begin
      qq = m << (-sh);
    end
    e = sh + 1;
    if (e < 1) return {2'b01, 9'd0};
    if (e > 15) return {2'b10, neg, 8'hFF};
    return {2'b00, neg, 4'(e), 4'(qq)};
  endfunction

  task automatic pin(string name, logic [8:0] a, logic [8:0] b,
                     logic op, logic [10:0] want);
    logic [10:0] got;
    got = ref_op(a, b, op);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL model_%s got=%h want=%h", name, got, want);
  endtask

  logic [8:0] last_s;
  logic       last_z, last_o;

  task automatic chk(string name, logic [8:0] s, logic z, logic o,
                     logic v, logic [8:0] ws, logic wz, logic wo,
                     logic wv);
    n_chk++;
    if (s === ws && z === wz && o === wo && v === wv) n_pass++;
    else
      $display("FAIL %s cyc=%0d got S=%b Z=%b O=%b V=%b want S=%b Z=%b O=%b V=%b",
               name, cyc, s, z, o, v, ws, wz, wo, wv);
  endtask

  // monitor: model scoreboard + per-cycle compare
  initial begin
    last_s = 9'd0;
    last_z = 1'b1;
    last_o = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        q.delete();
      end else if (bus.in_valid) begin
        q.push_back('{cyc + 2, ref_op(bus.A, bus.B, bus.ADDSUB)});
      end
      #1;
      if (rst) begin
        last_s = 9'd0;
        last_z = 1'b1;
        last_o = 1'b0;
        chk("reset", bus.S, bus.ZERO, bus.OVF, bus.out_valid,
            9'd0, 1'b1, 1'b0, 1'b0);
      end else if (q.size() > 0 && q[0].due == cyc) begin
        last_s = q[0].r[8:0];
        last_z = q[0].r[9];
        last_o = q[0].r[10];
        chk("result", bus.S, bus.ZERO, bus.OVF, bus.out_valid,
            last_s, last_z, last_o, 1'b1);
        void'(q.pop_front());
      end else begin
        chk("idle_hold", bus.S, bus.ZERO, bus.OVF, bus.out_valid,
            last_s, last_z, last_o, 1'b0);
      end
    end
  end

  task automatic drive(logic v, logic [8:0] a, logic [8:0] b, logic op);
    @(negedge clk);
    bus.in_valid = v;
    bus.A = a;
    bus.B = b;
    bus.ADDSUB = op;
  endtask

  function automatic logic [8:0] rnd_op();
    logic [8:0] x;
    x = 9'($urandom);
    case ($urandom_range(0, 9))
      0: x[7:4] = 4'd0;
      1: x[7:4] = 4'd15;
      2: x[7:4] = 4'd7;
      default: ;
    endcase
    return x;
  endfunction

  initial begin
    logic [8:0] a, b;
    bus.in_valid = 1'b0;
    bus.A = 9'd0;
    bus.B = 9'd0;
    bus.ADDSUB = 1'b0;

    pin("add", 9'b0_0101_0000, 9'b0_0100_0000, 1'b0, {2'b00, 9'b0_0101_1000});
    pin("cancel", 9'b0_0001_0000, 9'b0_0001_0000, 1'b1, {2'b01, 9'd0});
    pin("neg", 9'b0_0111_0000, 9'b0_0111_1000, 1'b1, {2'b00, 9'b1_0110_0000});
    pin("tie", 9'b0_1011_1100, 9'b0_0111_1000, 1'b1, {2'b00, 9'b0_1011_1010});
    pin("ovf", 9'b0_1111_1111, 9'b0_1111_1111, 1'b0, {2'b10, 9'b0_1111_1111});
    pin("xplus0", 9'b1_1111_1111, 9'b0_0000_0101, 1'b0, {2'b00, 9'b1_1111_1111});
    pin("zminus", 9'b0_0000_0011, 9'b0_0110_0110, 1'b1, {2'b00, 9'b1_0110_0110});
    pin("zz", 9'b1_0000_0000, 9'b0_0000_0000, 1'b1, {2'b01, 9'd0});
    pin("uflow", 9'b0_0001_0001, 9'b0_0001_0000, 1'b1, {2'b01, 9'd0});

    repeat (3) @(negedge clk);
    rst = 1'b0;

    drive(1'b1, 9'b0_0101_0000, 9'b0_0100_0000, 1'b0);
    drive(1'b1, 9'b0_0001_0000, 9'b0_0001_0000, 1'b1);
    drive(1'b1, 9'b0_0111_0000, 9'b0_0111_1000, 1'b1);
    drive(1'b1, 9'b0_1011_1100, 9'b0_0111_1000, 1'b1);
    drive(1'b1, 9'b0_1111_1111, 9'b0_1111_1111, 1'b0);
    drive(1'b1, 9'b0_0000_0000, 9'b1_0000_0000, 1'b1);
    drive(1'b0, 9'd0, 9'd0, 1'b0);
    repeat (4) drive(1'b0, 9'd0, 9'd0, 1'b0);

    drive(1'b1, 9'b0_0101_0000, 9'b0_0100_0000, 1'b0);
    drive(1'b1, 9'b0_0111_0000, 9'b0_0111_1000, 1'b1);
    rst = 1'b1;
    drive(1'b1, 9'b0_1011_1100, 9'b0_0111_1000, 1'b1);
    rst = 1'b0;
    repeat (4) drive(1'b0, 9'd0, 9'd0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      a = rnd_op();
      b = rnd_op();
      if ($urandom_range(0, 7) == 0) b[7:0] = a[7:0];
      if ($urandom_range(0, 7) == 0) b[7:4] = a[7:4];
      drive($urandom_range(0, 9) < 8, a, b, 1'($urandom));
      rst = ($urandom_range(0, 149) == 0);
    end
    rst = 1'b0;
    repeat (5) drive(1'b0, 9'd0, 9'd0, 1'b0);
    @(negedge clk);

    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
